key_switch_reader: RTL and testbench

- Input-side bus peripheral and the read counterpart of the seven-segment display writer.
- Synchronises and debounces 24 slide switches and 8 push keys.
- Latches key-press events into sticky flags and raises an interrupt.
- Presents everything to the CPU through the bridge as four 32-bit registers with combinational read, so a single-cycle core reads in the same cycle.

---
 rtl/key_switch_reader_pkg.sv | 19 +
 rtl/input_debounce.sv | 41 ++++
 rtl/key_switch_reader.sv | 99 +++++++++
 tb/tb_key_switch_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_switch_reader_pkg.sv
// Shared register offsets, port widths and default timing for the key/switch reader.
package key_switch_reader_pkg;

  localparam logic [1:0] ADDR_SW   = 2'b00;
  localparam logic [1:0] ADDR_KEY  = 2'b01;
  localparam logic [1:0] ADDR_EVT  = 2'b10;
  localparam logic [1:0] ADDR_MASK = 2'b11;

  localparam int SW_W  = 24;
  localparam int KEY_W = 8;

  // 200000 cycles is about 4 ms at 50 MHz, comfortably longer than contact bounce.
  localparam logic [29:0] DEB_TIME_DEFAULT = 30'd200000;

  function automatic logic [31:0] zext_key(input logic [KEY_W-1:0] v);
    return {{(32-KEY_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a two-sample agreement filter clocked by a shared tick.
module input_debounce #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;
  logic [W-1:0] agree;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign agree = ~(sync2 ^ prev);

  // A bit only moves when two consecutive tick samples agree, so any glitch shorter
  // than one tick period can be seen by at most one sample and never reaches dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= '0;
      dout <= '0;
    end else if (tick) begin
      prev <= sync2;
      dout <= (sync2 & agree) | (dout & ~agree);
    end
  end

endmodule

// File: rtl/key_switch_reader.sv
// Bus peripheral exposing debounced switches, keys, sticky key-press flags and an
// interrupt mask as four 32-bit registers with combinational read-back.
module key_switch_reader
  import key_switch_reader_pkg::*;
#(
  parameter logic [29:0] DEB_TIME = DEB_TIME_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  input  logic [KEY_W-1:0] key,
  input  logic [31:0]      addr_from_bridge,
  input  logic             we_from_bridge,
  input  logic [31:0]      data_from_bridge,
  output logic [31:0]      data_to_bridge,
  output logic             irq
);

  logic [29:0]      tick_cnt;
  logic             tick;
  logic [SW_W-1:0]  sw_deb;
  logic [KEY_W-1:0] key_deb;
  logic [KEY_W-1:0] key_prev;
  logic [KEY_W-1:0] key_rise;
  logic [KEY_W-1:0] key_evt;
  logic [KEY_W-1:0] irq_mask;
  logic [KEY_W-1:0] evt_clr;
  logic [1:0]       reg_sel;
  logic             evt_wr;
  logic             mask_wr;
  logic             unused_bus_bits;

  // One counter drives both debouncers so switches and keys are sampled on the same tick.
  assign tick = (tick_cnt == DEB_TIME - 30'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 30'd1;
    end
  end

  input_debounce #(.W(SW_W)) u_sw_debounce (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .din  (sw),
    .dout (sw_deb)
  );

  input_debounce #(.W(KEY_W)) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .din  (key),
    .dout (key_deb)
  );

  assign reg_sel  = addr_from_bridge[3:2];
  assign evt_wr   = we_from_bridge && (reg_sel == ADDR_EVT);
  assign mask_wr  = we_from_bridge && (reg_sel == ADDR_MASK);
  assign evt_clr  = evt_wr ? data_from_bridge[KEY_W-1:0] : '0;
  assign key_rise = key_deb & ~key_prev;

  assign unused_bus_bits = &{1'b0, addr_from_bridge[31:4], addr_from_bridge[1:0],
                             data_from_bridge[31:KEY_W]};

  // The rising edge is ORed in after the clear so a press landing on a W1C is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev <= '0;
      key_evt  <= '0;
      irq_mask <= '0;
    end else begin
      key_prev <= key_deb;
      key_evt  <= (key_evt & ~evt_clr) | key_rise;
      if (mask_wr) begin
        irq_mask <= data_from_bridge[KEY_W-1:0];
      end
    end
  end

  assign irq = |(key_evt & irq_mask);

  always_comb begin
    data_to_bridge = '0;
    case (reg_sel)
      ADDR_SW:   data_to_bridge = {{(32-SW_W){1'b0}}, sw_deb};
      ADDR_KEY:  data_to_bridge = zext_key(key_deb);
      ADDR_EVT:  data_to_bridge = zext_key(key_evt);
      ADDR_MASK: data_to_bridge = zext_key(irq_mask);
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_key_switch_reader.sv
// Randomised bench for key_switch_reader with a tick-sample reference model and directed checks.
module tb_key_switch_reader;

  localparam int DEB = 4;

  logic        clk;
  logic        rst;
  logic [23:0] sw;
  logic [7:0]  key;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int tests;
  int fails;

  key_switch_reader #(.DEB_TIME(30'd4)) dut (
    .clk              (clk),
    .rst              (rst),
    .sw               (sw),
    .key              (key),
    .addr_from_bridge (addr),
    .we_from_bridge   (we),
    .data_from_bridge (wdata),
    .data_to_bridge   (rdata),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  // Reference model: raw history two edges deep, a tick every DEB edges since reset,
  // and a debounced value that adopts a tick sample only if it matches the previous one.
  logic [31:0] m_h1, m_h2, m_last, m_deb, m_sample, m_stable;
  logic [7:0]  m_key_seen, m_evt, m_mask, m_rise, m_clr;
  int unsigned m_edge;

  initial begin
    m_h1 = '0; m_h2 = '0; m_last = '0; m_deb = '0;
    m_key_seen = '0; m_evt = '0; m_mask = '0; m_edge = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_h1 = '0; m_h2 = '0; m_last = '0; m_deb = '0;
        m_key_seen = '0; m_evt = '0; m_mask = '0; m_edge = 0;
      end else begin
        m_rise = m_deb[7:0] & ~m_key_seen;
        m_clr  = (we && addr[3:2] == 2'b10) ? wdata[7:0] : 8'h00;
        m_evt  = (m_evt & ~m_clr) | m_rise;
        if (we && addr[3:2] == 2'b11) m_mask = wdata[7:0];
        m_key_seen = m_deb[7:0];
        if ((m_edge % DEB) == DEB - 1) begin
          m_sample = m_h2;
          m_stable = ~(m_sample ^ m_last);
          m_deb    = (m_deb & ~m_stable) | (m_sample & m_stable);
          m_last   = m_sample;
        end
        m_h2 = m_h1;
        m_h1 = {sw, key};
        m_edge++;
      end
    end
  end

  function automatic logic [31:0] expRead(input logic [31:0] a);
    case (a[3:2])
      2'b00:   return {8'h00, m_deb[31:8]};
      2'b01:   return {24'h0, m_deb[7:0]};
      2'b10:   return {24'h0, m_evt};
      default: return {24'h0, m_mask};
    endcase
  endfunction

  // Every negedge the read data and irq must agree with the model.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (rdata !== expRead(addr)) begin
        fails++;
        $display("[TB] FAIL model_read addr=%h: got %h, expected %h", addr, rdata, expRead(addr));
      end
      tests++;
      if (irq !== (|(m_evt & m_mask))) begin
        fails++;
        $display("[TB] FAIL model_irq: got %b, expected %b", irq, |(m_evt & m_mask));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [23:0] s, input logic [7:0] k);
    sw  = s;
    key = k;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step(1);
    we    = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    @(negedge clk);
    #1;
    v = rdata;
  endtask

  logic [31:0] v;
  logic        found;
  logic        prev_irq;
  int          idx;
  int          hold;
  int          act;

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0; rst = 1'b1; sw = '0; key = '0; addr = '0; we = 1'b0; wdata = '0;
    #1 rst = 1'b0;
    step(2);
    for (int a = 0; a < 4; a++) begin
      readReg(32'(a) << 2, v);
      checkOutput("power_on_reg", v, 32'h0);
    end
    checkOutput("power_on_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    step(3);

    // Reset mid-run with a new switch pattern, then bounded wait for it to appear.
    applyStimulus(24'h123456, 8'h00);
    step(7);
    applyStimulus(24'hABCDEF, 8'h00);
    rst = 1'b0;
    step(1);
    for (int a = 0; a < 4; a++) begin
      readReg(32'(a) << 2, v);
      checkOutput("reset_reg", v, 32'h0);
    end
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      readReg(32'h0, v);
      if (v == 32'h00ABCDEF) found = 1'b1;
    end
    checkOutput("reset_sw_latency", {31'b0, found}, 32'h1);
    checkOutput("model_sw_after_reset", m_deb, 32'hABCDEF00);
    step(2);

    // Glitch rejection, then a real press.
    applyStimulus(24'hABCDEF, 8'h01);
    step(3);
    applyStimulus(24'hABCDEF, 8'h00);
    step(12);
    readReg(32'h4, v);
    checkOutput("glitch_key", v, 32'h0);
    readReg(32'h8, v);
    checkOutput("glitch_evt", v, 32'h0);
    step(1);
    applyStimulus(24'hABCDEF, 8'h01);
    step(12);
    readReg(32'h4, v);
    checkOutput("hold_key", v, 32'h01);
    checkOutput("model_key_hold", {24'h0, m_deb[7:0]}, 32'h01);
    step(1);
    readReg(32'h8, v);
    checkOutput("hold_evt", v, 32'h01);
    step(1);
    applyStimulus(24'hABCDEF, 8'h00);
    step(14);

    // Interrupt raised with the flag and dropped by W1C.
    busWrite(32'h8, 32'h01);
    readReg(32'h8, v);
    checkOutput("evt_cleared", v, 32'h0);
    step(1);
    busWrite(32'hC, 32'h01);
    applyStimulus(24'hABCDEF, 8'h01);
    found = 1'b0;
    prev_irq = 1'b0;
    for (int i = 0; i < 14 && !found; i++) begin
      prev_irq = irq;
      step(1);
      readReg(32'h8, v);
      if (v[0]) found = 1'b1;
    end
    checkOutput("irq_evt_seen", {31'b0, found}, 32'h1);
    checkOutput("irq_before_evt", {31'b0, prev_irq}, 32'h0);
    checkOutput("irq_with_evt", {31'b0, irq}, 32'h1);
    step(1);
    busWrite(32'h8, 32'h01);
    readReg(32'h8, v);
    checkOutput("w1c_evt", v, 32'h0);
    checkOutput("w1c_irq", {31'b0, irq}, 32'h0);
    step(1);
    applyStimulus(24'hABCDEF, 8'h00);
    step(14);

    // Mask gating.
    busWrite(32'hC, 32'h0);
    applyStimulus(24'hABCDEF, 8'h08);
    found = 1'b0;
    for (int i = 0; i < 14 && !found; i++) begin
      step(1);
      readReg(32'h8, v);
      if (v[3]) found = 1'b1;
    end
    checkOutput("mask_evt_seen", {31'b0, found}, 32'h1);
    checkOutput("masked_irq", {31'b0, irq}, 32'h0);
    step(1);
    busWrite(32'hC, 32'h08);
    readReg(32'hC, v);
    checkOutput("unmasked_irq", {31'b0, irq}, 32'h1);
    step(1);
    applyStimulus(24'hABCDEF, 8'h00);
    step(14);
    busWrite(32'h8, 32'hFF);

    // Set beats clear: W1C lands on the edge that records the rise.
    applyStimulus(24'hABCDEF, 8'h04);
    found = 1'b0;
    for (int i = 0; i < 14 && !found; i++) begin
      step(1);
      readReg(32'h4, v);
      if (v[2]) found = 1'b1;
    end
    checkOutput("sbc_key_seen", {31'b0, found}, 32'h1);
    addr = 32'h8; wdata = 32'h04; we = 1'b1;
    @(posedge clk);
    #2 we = 1'b0;
    readReg(32'h8, v);
    checkOutput("set_beats_clear", v, 32'h04);
    step(1);
    applyStimulus(24'h000000, 8'h00);
    step(14);
    busWrite(32'h8, 32'hFF);

    // Read-only registers and address aliasing.
    busWrite(32'h0, 32'hFFFFFFFF);
    readReg(32'h0, v);
    checkOutput("sw_read_only", v, 32'h0);
    step(1);
    busWrite(32'h4, 32'hFFFFFFFF);
    readReg(32'h4, v);
    checkOutput("key_read_only", v, 32'h0);
    step(1);
    busWrite(32'hC, 32'h5A);
    readReg(32'h1C, v);
    checkOutput("alias_mask", v, 32'h5A);
    step(1);

    // Randomised traffic; the compare process checks every cycle.
    for (int it = 0; it < 400; it++) begin
      act = $urandom_range(0, 19);
      if (act < 8) begin
        if ($urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, 23);
          sw[idx] = ~sw[idx];
        end
        idx = $urandom_range(0, 7);
        key[idx] = ~key[idx];
        hold = $urandom_range(1, 14);
        for (int j = 0; j < hold; j++) begin
          addr = $urandom;
          step(1);
        end
      end else if (act < 12) begin
        busWrite($urandom, $urandom);
      end else if (act < 15) begin
        v = $urandom;
        busWrite({v[31:4], 2'b10, v[1:0]}, {24'h0, 8'($urandom)});
      end else if (act == 19 && $urandom_range(0, 3) == 0) begin
        rst = 1'b0;
        step(1);
        rst = 1'b1;
      end else begin
        addr = $urandom;
        step(1);
      end
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
